gray_stream_feeder: RTL and testbench

Upstream stage of the edge-detection pipeline. Converts the camera/SDRAM RGB pixel stream to `DATA_SIZE`-bit luma and re-times it into the free-running raster the line-buffer processing block expects: one pixel per clock, framed by a single start pulse. Sits between the SDRAM read port / VGA request logic and the Gaussian/Sobel/NonMax/Hysteresis pipeline, driving that block's `i_is_new_read` and `i_data`.

---
 rtl/gray_stream_feeder_pkg.sv | 28 ++
 rtl/gray_stream_feeder_rgb2luma.sv | 62 ++++++
 rtl/gray_stream_feeder.sv | 158 +++++++++++++++
 tb/tb_gray_stream_feeder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_stream_feeder_pkg.sv
// Purpose : shared types and constants for the gray stream feeder.
// Latency : n/a (package only).
// Backpressure: n/a; the stream it describes is free-running.
// Contents: frame FSM state enum, BT.601-style luma weights, default raster size.
package gray_stream_feeder_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_STREAM = 2'd2
    } state_e;

    // Luma weights; they sum to 256 so the weighted sum never overflows IN_WIDTH+8 bits.
    localparam int unsigned LUMA_CR = 77;
    localparam int unsigned LUMA_CG = 150;
    localparam int unsigned LUMA_CB = 29;

    // Raster size including blanking, chosen by the same mode macro as the rest of the
    // pipeline. 640x480p60 is also the fallback until another mode is wired up.
`ifdef VGA_640x480p60
    localparam int unsigned DEF_H_LIMIT = 800;
    localparam int unsigned DEF_V_LIMIT = 525;
`else
    localparam int unsigned DEF_H_LIMIT = 800;
    localparam int unsigned DEF_V_LIMIT = 525;
`endif

endpackage

// File: rtl/gray_stream_feeder_rgb2luma.sv
// Purpose : weighted RGB -> luma, top DATA_SIZE bits of (77R+150G+29B)>>8.
// Latency : 2 clocks (products, then sum slice), valid sideband travels alongside.
// Backpressure: none; accepts a pixel every clock.
// Ports: i_clk/i_rst (sync, active-high), i_vld + i_r/i_g/i_b in, o_vld + o_luma out.
module rgb2luma
    import gray_stream_feeder_pkg::*;
#(
    parameter int IN_WIDTH  = 10,
    parameter int DATA_SIZE = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_vld,
    input  logic [IN_WIDTH-1:0]  i_r,
    input  logic [IN_WIDTH-1:0]  i_g,
    input  logic [IN_WIDTH-1:0]  i_b,
    output logic                 o_vld,
    output logic [DATA_SIZE-1:0] o_luma
);

    localparam int SW = IN_WIDTH + 8;
    localparam logic [SW-1:0] CR = SW'(LUMA_CR);
    localparam logic [SW-1:0] CG = SW'(LUMA_CG);
    localparam logic [SW-1:0] CB = SW'(LUMA_CB);

    logic [SW-1:0]        prod_r_d, prod_g_d, prod_b_d;
    logic [SW-1:0]        prod_r_q, prod_g_q, prod_b_q;
    logic                 vld_s1_q;
    logic [SW-1:0]        sum_d;
    logic [DATA_SIZE-1:0] luma_q;
    logic                 vld_s2_q;

    always_comb begin
        prod_r_d = SW'(i_r) * CR;
        prod_g_d = SW'(i_g) * CG;
        prod_b_d = SW'(i_b) * CB;
        sum_d    = prod_r_q + prod_g_q + prod_b_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prod_r_q <= '0;
            prod_g_q <= '0;
            prod_b_q <= '0;
            vld_s1_q <= 1'b0;
            luma_q   <= '0;
            vld_s2_q <= 1'b0;
        end else begin
            prod_r_q <= prod_r_d;
            prod_g_q <= prod_g_d;
            prod_b_q <= prod_b_d;
            vld_s1_q <= i_vld;
            // Truncating slice: top bits of sum>>8, no rounding.
            luma_q   <= sum_d[SW-1 -: DATA_SIZE];
            vld_s2_q <= vld_s1_q;
        end
    end

    assign o_vld  = vld_s2_q;
    assign o_luma = luma_q;

endmodule

// File: rtl/gray_stream_feeder.sv
// Purpose : frame FSM + free-running raster counters feeding luma to the edge pipeline.
// Latency : 2 clocks from RGB inputs to o_data; framing outputs delayed to match.
// Backpressure: none; once streaming, exactly H_LIMIT*V_LIMIT clocks are emitted.
// Ports: i_clk, i_rst (sync active-high), i_frame_start, i_pix_valid, i_R/i_G/i_B in;
//        o_is_new_read, o_data, o_h_cnt, o_v_cnt, o_busy, o_sync_err (sticky) out.
module gray_stream_feeder
    import gray_stream_feeder_pkg::*;
#(
    parameter int H_LIMIT   = DEF_H_LIMIT,
    parameter int V_LIMIT   = DEF_V_LIMIT,
    parameter int IN_WIDTH  = 10,
    parameter int DATA_SIZE = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_frame_start,
    input  logic                 i_pix_valid,
    input  logic [IN_WIDTH-1:0]  i_R,
    input  logic [IN_WIDTH-1:0]  i_G,
    input  logic [IN_WIDTH-1:0]  i_B,
    output logic                 o_is_new_read,
    output logic [DATA_SIZE-1:0] o_data,
    output logic [10:0]          o_h_cnt,
    output logic [9:0]           o_v_cnt,
    output logic                 o_busy,
    output logic                 o_sync_err
);

    localparam logic [10:0] H_LAST = 11'(H_LIMIT - 1);
    localparam logic [9:0]  V_LAST = 10'(V_LIMIT - 1);

    state_e      state_q, state_d;
    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        err_q, err_d;

    // Position of the pixel being counted this cycle (stage 0 of the pipeline).
    logic        cur_act;
    logic        cur_first;
    logic [10:0] cur_h;
    logic [9:0]  cur_v;
    logic        cur_last;

    // Framing sideband, delayed to line up with the luma pipeline.
    logic        busy_s1_q, first_s1_q;
    logic [10:0] h_s1_q;
    logic [9:0]  v_s1_q;
    logic        busy_s2_q, first_s2_q;
    logic [10:0] h_s2_q;
    logic [9:0]  v_s2_q;

    logic                 luma_vld;
    logic [DATA_SIZE-1:0] luma;

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        err_d     = err_q;
        cur_act   = 1'b0;
        cur_first = 1'b0;
        cur_h     = '0;
        cur_v     = '0;

        case (state_q)
            S_IDLE: begin
                if (i_frame_start) state_d = S_ARM;
            end
            S_ARM: begin
                // The first valid pixel is (0,0); a repeated frame start just keeps us armed.
                if (i_pix_valid) begin
                    cur_act   = 1'b1;
                    cur_first = 1'b1;
                end
            end
            S_STREAM: begin
                cur_act = 1'b1;
                cur_h   = h_q;
                cur_v   = v_q;
            end
            default: state_d = S_IDLE;
        endcase

        cur_last = (cur_h == H_LAST) && (cur_v == V_LAST);

        if (cur_act) begin
            if (cur_h == H_LAST) begin
                h_d = '0;
                v_d = (cur_v == V_LAST) ? '0 : cur_v + 10'd1;
            end else begin
                h_d = cur_h + 11'd1;
                v_d = cur_v;
            end

            if (cur_last) begin
                // A frame start on the final pixel chains straight into the next frame.
                state_d = (i_frame_start && state_q == S_STREAM) ? S_ARM : S_IDLE;
            end else begin
                state_d = S_STREAM;
                // Mid-frame frame start: keep the raster intact, just flag it.
                if (i_frame_start && state_q == S_STREAM) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            h_q        <= '0;
            v_q        <= '0;
            err_q      <= 1'b0;
            busy_s1_q  <= 1'b0;
            first_s1_q <= 1'b0;
            h_s1_q     <= '0;
            v_s1_q     <= '0;
            busy_s2_q  <= 1'b0;
            first_s2_q <= 1'b0;
            h_s2_q     <= '0;
            v_s2_q     <= '0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            v_q        <= v_d;
            err_q      <= err_d;
            busy_s1_q  <= cur_act;
            first_s1_q <= cur_first;
            h_s1_q     <= cur_h;
            v_s1_q     <= cur_v;
            busy_s2_q  <= busy_s1_q;
            first_s2_q <= first_s1_q;
            h_s2_q     <= h_s1_q;
            v_s2_q     <= v_s1_q;
        end
    end

    rgb2luma #(
        .IN_WIDTH  (IN_WIDTH),
        .DATA_SIZE (DATA_SIZE)
    ) u_rgb2luma (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_vld  (cur_act & i_pix_valid),
        .i_r    (i_R),
        .i_g    (i_G),
        .i_b    (i_B),
        .o_vld  (luma_vld),
        .o_luma (luma)
    );

    // Blanking and idle cycles carry zero luma.
    assign o_data        = luma_vld ? luma : '0;
    assign o_is_new_read = first_s2_q;
    assign o_h_cnt       = h_s2_q;
    assign o_v_cnt       = v_s2_q;
    assign o_busy        = busy_s2_q;
    assign o_sync_err    = err_q;

endmodule

// File: tb/tb_gray_stream_feeder.sv
module tb_gray_stream_feeder;

    localparam int H = 8;
    localparam int V = 4;
    localparam int N = H * V;

    typedef struct packed {
        logic        busy;
        logic        nr;
        logic [10:0] h;
        logic [9:0]  v;
        logic [3:0]  data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fs_in = 1'b0;
    logic       pv_in = 1'b0;
    logic [9:0] r_in = '0, g_in = '0, b_in = '0;
    logic       o_is_new_read, o_busy, o_sync_err;
    logic [3:0] o_data;
    logic [10:0] o_h_cnt;
    logic [9:0]  o_v_cnt;

    always #5 clk = ~clk;

    gray_stream_feeder #(
        .H_LIMIT(H), .V_LIMIT(V), .IN_WIDTH(10), .DATA_SIZE(4)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_frame_start(fs_in), .i_pix_valid(pv_in),
        .i_R(r_in), .i_G(g_in), .i_B(b_in),
        .o_is_new_read(o_is_new_read), .o_data(o_data), .o_h_cnt(o_h_cnt),
        .o_v_cnt(o_v_cnt), .o_busy(o_busy), .o_sync_err(o_sync_err)
    );

    int   n_pass = 0, n_total = 0;
    int   busy_cnt = 0, nr_cnt = 0;
    exp_t d1 = '0, d2 = '0;
    int   m_mode = 0;   // 0 idle, 1 armed, 2 streaming
    int   m_p = 0;      // raster index of next pixel, v*H+h
    bit   m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [3:0] luma(input int r, input int g, input int b);
        int s;
        s = 77 * r + 150 * g + 29 * b;
        return 4'(s >> 14);
    endfunction

    function automatic exp_t pix(input int p, input bit pv, input int r, input int g, input int b,
                                 input bit first);
        exp_t e;
        e.busy = 1'b1;
        e.nr   = first;
        e.h    = 11'(p % H);
        e.v    = 10'(p / H);
        e.data = pv ? luma(r, g, b) : 4'h0;
        return e;
    endfunction

    // One clock: compare outputs against the model, drive new inputs, advance the model.
    task automatic cycle(input bit fs, input bit pv, input logic [9:0] r, input logic [9:0] g,
                         input logic [9:0] b, input bit rs);
        exp_t e, got;
        @(negedge clk);
        got = {o_busy, o_is_new_read, o_h_cnt, o_v_cnt, o_data};
        check("outputs{busy,nr,h,v,data}", 32'(got), 32'(d2));
        check("sync_err", 32'(o_sync_err), 32'(m_err));
        if (o_busy) busy_cnt++;
        if (o_is_new_read) nr_cnt++;
        fs_in = fs; pv_in = pv; r_in = r; g_in = g; b_in = b; rst = rs;
        e = '0;
        if (rs) begin
            m_mode = 0; m_p = 0; m_err = 1'b0;
        end else begin
            case (m_mode)
                0: if (fs) m_mode = 1;
                1: if (pv) begin
                    e = pix(0, pv, r, g, b, 1'b1);
                    m_p = 1; m_mode = 2;
                end
                default: begin
                    e = pix(m_p, pv, r, g, b, 1'b0);
                    if (m_p == N - 1) begin
                        m_p = 0; m_mode = fs ? 1 : 0;
                    end else begin
                        m_p++;
                        if (fs) m_err = 1'b1;
                    end
                end
            endcase
        end
        d2 = d1; d1 = e;
        if (rs) begin d1 = '0; d2 = '0; end
    endtask

    function automatic logic [9:0] rnd();
        return 10'($urandom_range(0, 1023));
    endfunction

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'($urandom_range(0, 1)), rnd(), rnd(), rnd(), 1'b0);
    endtask

    task automatic frame(input bit lead_fs, input int fs_pix, input int blank_pix,
                         input int rst_pix, input bit directed);
        bit fs_k, pv_k;
        logic [9:0] r, g, b;
        if (lead_fs) begin
            cycle(1'b1, 1'b1, rnd(), rnd(), rnd(), 1'b0); // valid in idle is ignored
            cycle(1'b0, 1'b0, rnd(), rnd(), rnd(), 1'b0);
            cycle(1'b1, 1'b0, rnd(), rnd(), rnd(), 1'b0); // start while armed is ignored
        end
        for (int k = 0; k < N; k++) begin
            fs_k = (k == fs_pix);
            r = rnd(); g = rnd(); b = rnd();
            if (k == 0) pv_k = 1'b1;
            else if (k >= blank_pix && k < blank_pix + 3) begin
                pv_k = 1'b0; r = 10'h3FF; g = 10'h3FF; b = 10'h3FF;
            end else pv_k = ($urandom_range(0, 7) != 0);
            if (directed && k < 4) begin
                pv_k = 1'b1;
                r = (k == 0 || k == 1) ? 10'h3FF : 10'h0;
                g = (k == 0 || k == 2) ? 10'h3FF : 10'h0;
                b = (k == 0 || k == 3) ? 10'h3FF : 10'h0;
            end
            if (k == rst_pix) begin
                cycle(1'b0, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1);
                break;
            end
            cycle(fs_k, pv_k, r, g, b, 1'b0);
            if (directed) begin
                case (k)
                    1: check("new_read_early", 32'(o_is_new_read), 32'd0);
                    2: begin
                        check("white_data", 32'(o_data), 32'hF);
                        check("first_new_read", 32'(o_is_new_read), 32'd1);
                        check("first_h", 32'(o_h_cnt), 32'd0);
                        check("first_v", 32'(o_v_cnt), 32'd0);
                    end
                    3: begin
                        check("red_data", 32'(o_data), 32'h4);
                        check("new_read_once", 32'(o_is_new_read), 32'd0);
                        check("second_h", 32'(o_h_cnt), 32'd1);
                    end
                    4: check("green_data", 32'(o_data), 32'h9);
                    5: check("blue_data", 32'(o_data), 32'h1);
                    default: ;
                endcase
            end
            if (k >= blank_pix + 2 && k < blank_pix + 5) begin
                check("blank_data", 32'(o_data), 32'd0);
                check("blank_h", 32'(o_h_cnt), 32'((k - 2) % H));
            end
        end
    endtask

    initial begin
        // Pin the model's luma arithmetic with hand-computed values.
        check("model_white", 32'(luma(1023, 1023, 1023)), 32'hF);
        check("model_red", 32'(luma(1023, 0, 0)), 32'h4);
        check("model_green", 32'(luma(0, 1023, 0)), 32'h9);
        check("model_blue", 32'(luma(0, 0, 1023)), 32'h1);

        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
        cycle(1'b0, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b0);
        check("reset_data", 32'(o_data), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_new_read", 32'(o_is_new_read), 32'd0);
        check("reset_hv", 32'({o_h_cnt, o_v_cnt}), 32'd0);
        check("reset_err", 32'(o_sync_err), 32'd0);
        idle(3);

        // Directed first frame with a 3-cycle blanking gap at (4..6,1).
        busy_cnt = 0; nr_cnt = 0;
        frame(1'b1, -1, 12, -1, 1'b1);
        idle(4);
        check("frame_busy_cycles", 32'(busy_cnt), 32'(N));
        check("frame_new_reads", 32'(nr_cnt), 32'd1);
        check("busy_fell", 32'(o_busy), 32'd0);
        check("no_err", 32'(o_sync_err), 32'd0);

        // Frame start at pixel (3,1): frame completes, error sticks.
        busy_cnt = 0; nr_cnt = 0;
        frame(1'b1, 1 * H + 3, 1000, -1, 1'b0);
        idle(4);
        check("syncerr_busy_cycles", 32'(busy_cnt), 32'(N));
        check("syncerr_new_reads", 32'(nr_cnt), 32'd1);
        check("syncerr_set", 32'(o_sync_err), 32'd1);
        frame(1'b1, -1, 1000, -1, 1'b0);
        idle(2);
        check("syncerr_sticky", 32'(o_sync_err), 32'd1);

        // Reset at pixel (5,2), then valid pixels without a frame start.
        frame(1'b1, -1, 1000, 2 * H + 5, 1'b0);
        cycle(1'b0, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b0);
        check("midrst_outputs", 32'({o_busy, o_is_new_read, o_h_cnt, o_v_cnt, o_data}), 32'd0);
        check("midrst_err", 32'(o_sync_err), 32'd0);
        busy_cnt = 0; nr_cnt = 0;
        repeat (40) cycle(1'b0, 1'b1, rnd(), rnd(), rnd(), 1'b0);
        check("midrst_no_new_read", 32'(nr_cnt), 32'd0);
        check("midrst_no_busy", 32'(busy_cnt), 32'd0);

        // Back-to-back frames chained by a frame start on the last pixel.
        busy_cnt = 0; nr_cnt = 0;
        frame(1'b1, N - 1, 1000, -1, 1'b0);
        frame(1'b0, -1, 1000, -1, 1'b0);
        idle(4);
        check("b2b_new_reads", 32'(nr_cnt), 32'd2);
        check("b2b_busy_cycles", 32'(busy_cnt), 32'(2 * N));
        check("b2b_no_err", 32'(o_sync_err), 32'd0);

        // Randomized frames: random gaps, random stray frame starts, random blanking.
        for (int f = 0; f < 8; f++) begin
            idle($urandom_range(0, 5));
            frame(1'b1, $urandom_range(0, 2 * N), $urandom_range(1, 40), -1, 1'b0);
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
